tile_spawner: RTL and testbench
===============================

TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 SHALL have parameter WIDTH_P, default 10: playfield column count.
REQ-002 SHALL have parameter HEIGHT_P, default 22: playfield row count, unused except for COORD_W_P range checks.
REQ-003 SHALL have parameter DEPTH_P, default 4: preview queue entries, at least 2.
REQ-004 SHALL have parameter COORD_W_P, default 8: signed two's-complement coordinate width.
REQ-005 Ports SHALL be as follows.
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- in_v_i / in_ready_o  in/out  1/1  queue push handshake.
- in_type_i / in_angle_i  in  3/2  pushed tile type / angle.
- count_o  out  $clog2(DEPTH_P+1)  queue occupancy.
- spawn_req_i  in  1  spawn request pulse.
- rom_addr_o  out  5  {type, angle} shape-ROM address.
- rom_max_y_i  in  2  combinational ROM reply: tile max y.
- chk_v_o  out  1  collision check request.
- chk_done_i / chk_hit_i  in  1/1  check completion / collision result.
- tile_type_o / tile_angle_o  out  3/2  current tile.
- pos_x_o / pos_y_o  out  COORD_W_P each  signed spawn point.
- v_o  out  1  one-cycle "new tile placed" strobe.
- cm_is_ready_i  in  1  consumer finished with tile.
- done_o  out  1  one-cycle spawn-complete strobe.
- game_over_o  out  1  sticky blocked-spawn flag.
- hold_req_i  in  1  hold-swap request.
- hold_type_o / hold_angle_o  out  3/2  held tile; 0 means empty.

Function
REQ-006 The queue SHALL be a DEPTH_P-entry FIFO; push when in_v_i and in_ready_o; in_ready_o = (count_o < DEPTH_P).
- Push while full: dropped.
- Push and pop in the same cycle while not full: count unchanged.
REQ-007 A spawn_req_i pulse in any state SHALL set pending_r; pending_r clears on IDLE->FETCH.
REQ-008 The FSM SHALL have states IDLE, FETCH, CHECK, ISSUE, WAIT, OVER.
REQ-009 IDLE->FETCH SHALL occur when pending_r and the queue is not empty; the head is popped and latched into the current tile. If the queue is empty, the FSM stays in IDLE and pending_r is held.
REQ-010 FETCH SHALL take one cycle.
- rom_addr_o = {current type, angle}.
- Latch pos_x = WIDTH_P/2-2 and pos_y = ~zero-extended rom_max_y_i, i.e. -(max_y+1), sign-correct at COORD_W_P.
- Go to CHECK.
REQ-011 In CHECK, chk_v_o SHALL stay high until chk_done_i.
- chk_done_i with chk_hit_i=0: go to ISSUE.
- chk_done_i with chk_hit_i=1: go to OVER.
- chk_done_i in the first CHECK cycle is legal.
REQ-012 ISSUE SHALL assert v_o for exactly one cycle, then go to WAIT.
REQ-013 WAIT SHALL go to IDLE when cm_is_ready_i; done_o = (state==WAIT) & cm_is_ready_i, combinational.
REQ-014 OVER SHALL be absorbing until reset.
- game_over_o=1, v_o=0, chk_v_o=0.
- Pushes are still accepted.
REQ-015 tile_type_o, tile_angle_o, pos_x_o, pos_y_o SHALL change only on IDLE->FETCH (type, angle) or in FETCH (position), and hold otherwise.
REQ-016 Latency from spawn_req_i (queue non-empty, IDLE) to v_o SHALL be 4 cycles for a 1-cycle check: IDLE, FETCH, CHECK, ISSUE.

Reset
REQ-017 Assertion of reset_n_i SHALL immediately clear the FSM, queue and pending_r, and set all outputs to 0. After reset, in_ready_o=1.
REQ-018 Reset mid-operation, including in CHECK with chk_v_o high, SHALL abandon the tile with no done_o strobe.

Configuration
REQ-019 With macro TILE_SPAWNER_HOLD_EN defined, hold_req_i in WAIT with hold_used_r=0 SHALL move the current type/angle into hold, set hold_used_r, and go to FETCH.
- Hold empty: the source is the queue head, popped; if the queue is empty, the request is ignored.
- Hold occupied: the source is the held tile.
REQ-020 hold_used_r SHALL clear on done_o. hold_req_i in any other state, or with hold_used_r=1, SHALL be ignored.
REQ-021 Without TILE_SPAWNER_HOLD_EN, no hold storage SHALL exist, hold_req_i SHALL be ignored, and hold_type_o/hold_angle_o SHALL be tied to 0.

Verification
REQ-022 WIDTH_P=10: push (type 2, angle 1), spawn_req_i, rom_max_y_i=1, chk_done_i with chk_hit_i=0 on the first CHECK cycle -> v_o at cycle 4, pos_x=3, pos_y=8'hFE, tile 2/1.
REQ-023 DEPTH_P=4: push 5 tiles back-to-back -> in_ready_o=0 after 4, count_o=4, 5th dropped; spawn pops in order 1..4.
REQ-024 spawn_req_i with an empty queue, then push after 3 cycles -> FETCH the cycle after push, no lost request.
REQ-025 chk_hit_i=1 -> game_over_o=1, no v_o, later spawn_req_i has no effect until reset_n_i low.
REQ-026 HOLD_EN: in WAIT with tile A, queue head B, hold_req_i -> hold=A, v_o for B; second hold_req_i ignored; after done_o, hold_req_i -> swap returns A.
REQ-027 Drop reset_n_i during CHECK -> all outputs 0 same cycle, count_o=0, no done_o.

Source files
------------

// File: rtl/tile_spawner.sv
// -----------------------------------------------------------------------------
// tile_spawner
//   Holds a small preview queue of upcoming tiles and, on a spawn request,
//   pops the next tile, looks up its height in an external shape ROM, places
//   it at the top-centre spawn point, asks an external checker for a
//   collision, and either hands the tile to the consumer or enters a sticky
//   game-over state.
//
// Optional feature macro: TILE_SPAWNER_HOLD_EN
//   Defined   -> a one-slot hold buffer; hold_req_i in WAIT swaps the current
//                tile with the held one (or with the queue head if the hold is
//                empty), at most once per placed tile.
//   Undefined -> no hold storage; hold_req_i is ignored, hold outputs are 0.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   in_v_i/in_ready_o           queue push handshake
//   in_type_i/in_angle_i        pushed tile type / rotation
//   count_o                     queue occupancy
//   spawn_req_i                 spawn request pulse (remembered until served)
//   rom_addr_o/rom_max_y_i      shape-ROM address {type,angle} / max y reply
//   chk_v_o                     collision check request (held until done)
//   chk_done_i/chk_hit_i        check completion / collision result
//   tile_type_o/tile_angle_o    current tile
//   pos_x_o/pos_y_o             signed spawn position
//   v_o                         one-cycle "new tile placed" strobe
//   cm_is_ready_i               consumer has finished with the tile
//   done_o                      one-cycle spawn-complete strobe
//   game_over_o                 sticky: spawn was blocked
//   hold_req_i                  hold-swap request
//   hold_type_o/hold_angle_o    held tile (0 when empty)
// -----------------------------------------------------------------------------
module tile_spawner #(
   parameter int WIDTH_P   = 10,
   parameter int HEIGHT_P  = 22,
   parameter int DEPTH_P   = 4,
   parameter int COORD_W_P = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          in_v_i,
   output logic                          in_ready_o,
   input  logic [2:0]                    in_type_i,
   input  logic [1:0]                    in_angle_i,
   output logic [$clog2(DEPTH_P+1)-1:0]  count_o,
   input  logic                          spawn_req_i,
   output logic [4:0]                    rom_addr_o,
   input  logic [1:0]                    rom_max_y_i,
   output logic                          chk_v_o,
   input  logic                          chk_done_i,
   input  logic                          chk_hit_i,
   output logic [2:0]                    tile_type_o,
   output logic [1:0]                    tile_angle_o,
   output logic signed [COORD_W_P-1:0]   pos_x_o,
   output logic signed [COORD_W_P-1:0]   pos_y_o,
   output logic                          v_o,
   input  logic                          cm_is_ready_i,
   output logic                          done_o,
   output logic                          game_over_o,
   input  logic                          hold_req_i,
   output logic [2:0]                    hold_type_o,
   output logic [1:0]                    hold_angle_o
);

   localparam int CNT_W = $clog2(DEPTH_P + 1);
   localparam int PTR_W = $clog2(DEPTH_P);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_CHECK = 3'd2;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic signed [COORD_W_P-1:0] SPAWN_X = COORD_W_P'(WIDTH_P / 2 - 2);

   // Elaboration-time sanity checks on the parameter set.
   if (DEPTH_P < 2) begin : g_bad_depth
      $error("tile_spawner: DEPTH_P must be at least 2");
   end
   if ((WIDTH_P >= 2 ** (COORD_W_P - 1)) || (HEIGHT_P >= 2 ** (COORD_W_P - 1))) begin : g_bad_coord
      $error("tile_spawner: COORD_W_P too narrow for the playfield");
   end

   typedef struct packed {
      logic [2:0] kind;
      logic [1:0] angle;
   } tile_t;

   logic [2:0]                  state_q, state_d;
   logic                        pending_q, pending_d;
   tile_t                       cur_q, cur_d;
   logic signed [COORD_W_P-1:0] pos_x_q, pos_x_d;
   logic signed [COORD_W_P-1:0] pos_y_q, pos_y_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
   tile_t                       mem_q [DEPTH_P];

   logic  push, pop, have_entry;
   tile_t head;

   assign in_ready_o = (count_q < CNT_W'(DEPTH_P));
   assign push       = in_v_i && in_ready_o;
   // An empty queue forwards the tile being pushed this cycle, so a waiting
   // spawn request is served on the same edge the tile arrives.
   assign have_entry = (count_q != '0) || push;
   assign head       = (count_q == '0) ? tile_t'({in_type_i, in_angle_i}) : mem_q[rd_ptr_q];
   assign done_o     = (state_q == ST_WAIT) && cm_is_ready_i;

`ifdef TILE_SPAWNER_HOLD_EN
   tile_t hold_q, hold_d;
   logic  hold_valid_q, hold_valid_d;
   logic  hold_used_q, hold_used_d;
`else
   logic  unused_hold_req;
   assign unused_hold_req = hold_req_i;
`endif

   // NOTE: every next-state signal gets a default before the case statement,
   // so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q || spawn_req_i;
      cur_d     = cur_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      pop       = 1'b0;
`ifdef TILE_SPAWNER_HOLD_EN
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      hold_used_d  = done_o ? 1'b0 : hold_used_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if ((pending_q || spawn_req_i) && have_entry) begin
               pop       = 1'b1;
               cur_d     = head;
               pending_d = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            pos_x_d = SPAWN_X;
            // ~max_y == -(max_y + 1): the tile starts just above row 0.
            pos_y_d = ~{{(COORD_W_P - 2){1'b0}}, rom_max_y_i};
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (chk_done_i) state_d = chk_hit_i ? ST_OVER : ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cm_is_ready_i) begin
               state_d = ST_IDLE;
            end
`ifdef TILE_SPAWNER_HOLD_EN
            else if (hold_req_i && !hold_used_q) begin
               if (hold_valid_q) begin
                  hold_d      = cur_q;
                  cur_d       = hold_q;
                  hold_used_d = 1'b1;
                  state_d     = ST_FETCH;
               end else if (have_entry) begin
                  hold_d       = cur_q;
                  hold_valid_d = 1'b1;
                  cur_d        = head;
                  pop          = 1'b1;
                  hold_used_d  = 1'b1;
                  state_d      = ST_FETCH;
               end
            end
`endif
         end
         ST_OVER: state_d = ST_OVER;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         cur_q     <= '0;
         pos_x_q   <= '0;
         pos_y_q   <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cur_q     <= cur_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         count_q   <= count_d;
         if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH_P - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH_P - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   // NOTE: queue storage has no reset; the pointers and count decide which
   // entries are valid, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= tile_t'({in_type_i, in_angle_i});
   end

`ifdef TILE_SPAWNER_HOLD_EN
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_used_q  <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_used_q  <= hold_used_d;
      end
   end
   assign hold_type_o  = hold_q.kind;
   assign hold_angle_o = hold_q.angle;
`else
   assign hold_type_o  = 3'd0;
   assign hold_angle_o = 2'd0;
`endif

   assign count_o      = count_q;
   assign rom_addr_o   = cur_q;
   assign chk_v_o      = (state_q == ST_CHECK);
   assign v_o          = (state_q == ST_ISSUE);
   assign game_over_o  = (state_q == ST_OVER);
   assign tile_type_o  = cur_q.kind;
   assign tile_angle_o = cur_q.angle;
   assign pos_x_o      = pos_x_q;
   assign pos_y_o      = pos_y_q;

endmodule

// File: tb/tb_tile_spawner.sv
// -----------------------------------------------------------------------------
// tb_tile_spawner
//   Directed bench for tile_spawner (WIDTH_P=10, DEPTH_P=4, COORD_W_P=8).
//   Inputs change 1 time unit after the rising edge; outputs are read there.
//   Hold-feature expectations follow TILE_SPAWNER_HOLD_EN.
// -----------------------------------------------------------------------------
module tb_tile_spawner;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       in_v_i;
   logic       in_ready_o;
   logic [2:0] in_type_i;
   logic [1:0] in_angle_i;
   logic [2:0] count_o;
   logic       spawn_req_i;
   logic [4:0] rom_addr_o;
   logic [1:0] rom_max_y_i;
   logic       chk_v_o;
   logic       chk_done_i;
   logic       chk_hit_i;
   logic [2:0] tile_type_o;
   logic [1:0] tile_angle_o;
   logic [7:0] pos_x_o;
   logic [7:0] pos_y_o;
   logic       v_o;
   logic       cm_is_ready_i;
   logic       done_o;
   logic       game_over_o;
   logic       hold_req_i;
   logic [2:0] hold_type_o;
   logic [1:0] hold_angle_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   tile_spawner #(.WIDTH_P(10), .HEIGHT_P(22), .DEPTH_P(4), .COORD_W_P(8)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .in_v_i(in_v_i), .in_ready_o(in_ready_o),
      .in_type_i(in_type_i), .in_angle_i(in_angle_i), .count_o(count_o),
      .spawn_req_i(spawn_req_i), .rom_addr_o(rom_addr_o), .rom_max_y_i(rom_max_y_i),
      .chk_v_o(chk_v_o), .chk_done_i(chk_done_i), .chk_hit_i(chk_hit_i),
      .tile_type_o(tile_type_o), .tile_angle_o(tile_angle_o),
      .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .v_o(v_o),
      .cm_is_ready_i(cm_is_ready_i), .done_o(done_o), .game_over_o(game_over_o),
      .hold_req_i(hold_req_i), .hold_type_o(hold_type_o), .hold_angle_o(hold_angle_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [2:0] t, input logic [1:0] a);
      in_v_i = 1'b1; in_type_i = t; in_angle_i = a;
      tick();
      in_v_i = 1'b0;
   endtask

   // From FETCH: CHECK, ISSUE, then WAIT (check completes in its first cycle).
   task automatic drive_to_wait();
      tick(); tick(); tick();
   endtask

   task automatic release_tile();
      cm_is_ready_i = 1'b1;
      tick();
      cm_is_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      in_v_i = 0; in_type_i = 0; in_angle_i = 0; spawn_req_i = 0;
      rom_max_y_i = 2'd1; chk_done_i = 1'b1; chk_hit_i = 0;
      cm_is_ready_i = 0; hold_req_i = 0;
      #3;
      checks++; if ({v_o, chk_v_o, done_o, game_over_o} !== 4'b0000) begin errors++;
         $display("FAIL reset_strobes got %b exp 0000", {v_o, chk_v_o, done_o, game_over_o}); end
      checks++; if ({count_o, tile_type_o, tile_angle_o, pos_x_o, pos_y_o} !== 26'd0) begin errors++;
         $display("FAIL reset_regs count=%0d type=%0d pos=%h/%h exp all 0", count_o, tile_type_o, pos_x_o, pos_y_o); end
      #9 reset_n_i = 1'b1;
      tick();
      checks++; if (in_ready_o !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
   endtask

   task automatic test_spawn_latency();
      push(3'd2, 2'd1);
      checks++; if (count_o !== 3'd1) begin errors++;
         $display("FAIL lat_count got %0d exp 1", count_o); end
      spawn_req_i = 1'b1;                       // cycle 1: IDLE
      tick(); spawn_req_i = 1'b0;               // cycle 2: FETCH
      checks++; if ({tile_type_o, tile_angle_o, rom_addr_o} !== {3'd2, 2'd1, 5'b01001}) begin errors++;
         $display("FAIL lat_tile got %0d/%0d addr %b exp 2/1 addr 01001", tile_type_o, tile_angle_o, rom_addr_o); end
      tick();                                   // cycle 3: CHECK
      checks++; if ({chk_v_o, pos_x_o, pos_y_o} !== {1'b1, 8'd3, 8'hFE}) begin errors++;
         $display("FAIL lat_pos chk_v=%b x=%h y=%h exp 1 03 fe", chk_v_o, pos_x_o, pos_y_o); end
      tick();                                   // cycle 4: ISSUE
      checks++; if ({v_o, chk_v_o} !== 2'b10) begin errors++;
         $display("FAIL lat_v_o got v=%b chk_v=%b exp 1 0", v_o, chk_v_o); end
      tick();                                   // WAIT
      checks++; if (v_o !== 1'b0) begin errors++;
         $display("FAIL lat_v_one_cycle got %b exp 0", v_o); end
      cm_is_ready_i = 1'b1; #1;
      checks++; if (done_o !== 1'b1) begin errors++;
         $display("FAIL lat_done got %b exp 1", done_o); end
      tick(); cm_is_ready_i = 1'b0;
      checks++; if (done_o !== 1'b0) begin errors++;
         $display("FAIL lat_done_one_cycle got %b exp 0", done_o); end
   endtask

   task automatic test_fifo_full();
      for (int i = 1; i <= 5; i++) begin
         push(i[2:0], 2'd0);
         if (i == 4) begin
            checks++; if ({in_ready_o, count_o} !== {1'b0, 3'd4}) begin errors++;
               $display("FAIL full_after4 ready=%b count=%0d exp 0 4", in_ready_o, count_o); end
         end
      end
      checks++; if (count_o !== 3'd4) begin errors++;
         $display("FAIL full_drop count got %0d exp 4", count_o); end
      for (int i = 1; i <= 4; i++) begin
         spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
         checks++; if (tile_type_o !== i[2:0]) begin errors++;
            $display("FAIL full_order pop %0d got type %0d exp %0d", i, tile_type_o, i); end
         drive_to_wait();
         release_tile();
      end
      checks++; if ({count_o, in_ready_o} !== {3'd0, 1'b1}) begin errors++;
         $display("FAIL full_drained count=%0d ready=%b exp 0 1", count_o, in_ready_o); end
   endtask

   task automatic test_pending();
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      tick(); tick();
      checks++; if ({tile_type_o, count_o, chk_v_o} !== {3'd4, 3'd0, 1'b0}) begin errors++;
         $display("FAIL pend_idle type=%0d count=%0d chk_v=%b exp 4 0 0", tile_type_o, count_o, chk_v_o); end
      rom_max_y_i = 2'd3;
      push(3'd6, 2'd2);                         // now in FETCH
      checks++; if ({tile_type_o, tile_angle_o, count_o} !== {3'd6, 2'd2, 3'd0}) begin errors++;
         $display("FAIL pend_fetch tile=%0d/%0d count=%0d exp 6/2 0", tile_type_o, tile_angle_o, count_o); end
      tick();
      checks++; if ({chk_v_o, pos_y_o} !== {1'b1, 8'hFC}) begin errors++;
         $display("FAIL pend_pos_y chk_v=%b y=%h exp 1 fc", chk_v_o, pos_y_o); end
      rom_max_y_i = 2'd1;
      tick(); tick();
      release_tile();
   endtask

   task automatic test_hold();
      push(3'd1, 2'd1);
      push(3'd2, 2'd2);
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      drive_to_wait();
      hold_req_i = 1'b1; tick(); hold_req_i = 1'b0;
`ifdef TILE_SPAWNER_HOLD_EN
      checks++; if ({hold_type_o, hold_angle_o, tile_type_o, count_o} !== {3'd1, 2'd1, 3'd2, 3'd0}) begin errors++;
         $display("FAIL hold_first hold=%0d/%0d type=%0d count=%0d exp 1/1 2 0", hold_type_o, hold_angle_o, tile_type_o, count_o); end
      tick(); tick();
      checks++; if ({v_o, tile_type_o} !== {1'b1, 3'd2}) begin errors++;
         $display("FAIL hold_issue v=%b type=%0d exp 1 2", v_o, tile_type_o); end
      tick();
      hold_req_i = 1'b1; tick(); hold_req_i = 1'b0;
      tick();
      checks++; if ({v_o, chk_v_o, tile_type_o, hold_type_o} !== {2'b00, 3'd2, 3'd1}) begin errors++;
         $display("FAIL hold_second_ignored v=%b chk=%b type=%0d hold=%0d exp 0 0 2 1", v_o, chk_v_o, tile_type_o, hold_type_o); end
      release_tile();
      push(3'd4, 2'd0);
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      drive_to_wait();
      hold_req_i = 1'b1; tick(); hold_req_i = 1'b0;
      checks++; if ({tile_type_o, tile_angle_o, hold_type_o, hold_angle_o} !== {3'd1, 2'd1, 3'd4, 2'd0}) begin errors++;
         $display("FAIL hold_swap tile=%0d/%0d hold=%0d/%0d exp 1/1 4/0", tile_type_o, tile_angle_o, hold_type_o, hold_angle_o); end
      tick(); tick();
      checks++; if (v_o !== 1'b1) begin errors++;
         $display("FAIL hold_swap_issue v got %b exp 1", v_o); end
      tick();
      release_tile();
`else
      checks++; if ({tile_type_o, hold_type_o, hold_angle_o, count_o} !== {3'd1, 3'd0, 2'd0, 3'd1}) begin errors++;
         $display("FAIL hold_off type=%0d hold=%0d/%0d count=%0d exp 1 0/0 1", tile_type_o, hold_type_o, hold_angle_o, count_o); end
      tick();
      checks++; if ({v_o, chk_v_o} !== 2'b00) begin errors++;
         $display("FAIL hold_off_stay v=%b chk=%b exp 0 0", v_o, chk_v_o); end
      release_tile();
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      checks++; if (tile_type_o !== 3'd2) begin errors++;
         $display("FAIL hold_off_next type got %0d exp 2", tile_type_o); end
      drive_to_wait();
      release_tile();
`endif
   endtask

   task automatic test_game_over();
      push(3'd3, 2'd0);
      chk_hit_i = 1'b1;
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      tick();                                   // CHECK
      checks++; if (chk_v_o !== 1'b1) begin errors++;
         $display("FAIL over_chk_v got %b exp 1", chk_v_o); end
      tick();                                   // OVER
      checks++; if ({game_over_o, v_o, chk_v_o} !== 3'b100) begin errors++;
         $display("FAIL over_enter go=%b v=%b chk=%b exp 1 0 0", game_over_o, v_o, chk_v_o); end
      push(3'd5, 2'd0);
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      tick();
      checks++; if ({game_over_o, v_o, count_o, tile_type_o} !== {2'b10, 3'd1, 3'd3}) begin errors++;
         $display("FAIL over_sticky go=%b v=%b count=%0d type=%0d exp 1 0 1 3", game_over_o, v_o, count_o, tile_type_o); end
      #2 reset_n_i = 1'b0; #1;
      checks++; if ({game_over_o, count_o} !== {1'b0, 3'd0}) begin errors++;
         $display("FAIL over_reset go=%b count=%0d exp 0 0", game_over_o, count_o); end
      reset_n_i = 1'b1; chk_hit_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_check();
      chk_done_i = 1'b0;
      push(3'd5, 2'd3);
      spawn_req_i = 1'b1; tick(); spawn_req_i = 1'b0;
      tick(); tick();
      checks++; if (chk_v_o !== 1'b1) begin errors++;
         $display("FAIL rst_chk_wait chk_v got %b exp 1", chk_v_o); end
      cm_is_ready_i = 1'b1;
      #2 reset_n_i = 1'b0; #1;
      checks++; if ({chk_v_o, v_o, done_o, game_over_o, count_o} !== 7'd0) begin errors++;
         $display("FAIL rst_mid_ctrl chk=%b v=%b done=%b go=%b count=%0d exp all 0", chk_v_o, v_o, done_o, game_over_o, count_o); end
      checks++; if ({tile_type_o, tile_angle_o, rom_addr_o, pos_x_o, pos_y_o} !== 26'd0) begin errors++;
         $display("FAIL rst_mid_data tile=%0d/%0d addr=%b pos=%h/%h exp all 0", tile_type_o, tile_angle_o, rom_addr_o, pos_x_o, pos_y_o); end
      #2 reset_n_i = 1'b1;
      chk_done_i = 1'b1;
      tick(); tick();
      checks++; if ({done_o, v_o, in_ready_o} !== 3'b001) begin errors++;
         $display("FAIL rst_after done=%b v=%b ready=%b exp 0 0 1", done_o, v_o, in_ready_o); end
      cm_is_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_spawn_latency();
      test_fifo_full();
      test_pending();
      test_hold();
      test_game_over();
      test_reset_in_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
